// File: rtl/serial_compare_driver.sv
// Producer side of the bit-serial unsigned compare link: accepts an operand pair, clears the
// comparator, streams both operands MSB-first, then captures the L/E/G flags as a result.
module serial_compare_driver #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_rst,
   output logic             ser_op,
   input  logic             cmp_l,
   input  logic             cmp_e,
   input  logic             cmp_g,
   output logic             res_valid,
   output logic             res_l,
   output logic             res_e,
   output logic             res_g,
   output logic             res_err
);

   localparam int unsigned CntW  = $clog2(WIDTH);
   localparam int unsigned WaitW = $clog2(SETTLE + 1);

   localparam logic [CntW-1:0]  LastBit  = CntW'(WIDTH - 1);
   localparam logic [WaitW-1:0] LastWait = WaitW'(SETTLE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StShift,
      StWait,
      StDone
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] sh_a_q;
   logic [WIDTH-1:0] sh_b_q;
   logic [CntW-1:0]  bit_cnt_q;
   logic [WaitW-1:0] wait_cnt_q;
   logic             flags_onehot;

   assign flags_onehot = (cmp_l ^ cmp_e ^ cmp_g) & ~(cmp_l & cmp_e & cmp_g);

   // Every output is loaded with the value belonging to the state being entered, so the
   // outputs always describe the current state while staying purely registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         sh_a_q     <= '0;
         sh_b_q     <= '0;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         in_ready   <= 1'b0;
         ser_a      <= 1'b0;
         ser_b      <= 1'b0;
         ser_rst    <= 1'b1;
         ser_op     <= 1'b1;
         res_valid  <= 1'b0;
         res_l      <= 1'b0;
         res_e      <= 1'b0;
         res_g      <= 1'b0;
         res_err    <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               in_ready <= 1'b1;
               ser_rst  <= 1'b1;
               ser_op   <= 1'b1;
               ser_a    <= 1'b0;
               ser_b    <= 1'b0;
               if (in_valid && in_ready) begin
                  sh_a_q   <= in_a;
                  sh_b_q   <= in_b;
                  in_ready <= 1'b0;
                  ser_op   <= 1'b0;
                  state_q  <= StClear;
               end
            end
            StClear: begin
               ser_rst   <= 1'b0;
               ser_a     <= sh_a_q[WIDTH-1];
               ser_b     <= sh_b_q[WIDTH-1];
               sh_a_q    <= {sh_a_q[WIDTH-2:0], 1'b0};
               sh_b_q    <= {sh_b_q[WIDTH-2:0], 1'b0};
               bit_cnt_q <= '0;
               state_q   <= StShift;
            end
            StShift: begin
               if (bit_cnt_q == LastBit) begin
                  // Zero pairs hold whatever decision the comparator has already reached.
                  ser_a      <= 1'b0;
                  ser_b      <= 1'b0;
                  wait_cnt_q <= '0;
                  state_q    <= StWait;
               end else begin
                  ser_a     <= sh_a_q[WIDTH-1];
                  ser_b     <= sh_b_q[WIDTH-1];
                  sh_a_q    <= {sh_a_q[WIDTH-2:0], 1'b0};
                  sh_b_q    <= {sh_b_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + CntW'(1);
               end
            end
            StWait: begin
               if (wait_cnt_q == LastWait) begin
                  res_valid <= 1'b1;
                  res_l     <= cmp_l;
                  res_e     <= cmp_e;
                  res_g     <= cmp_g;
                  res_err   <= ~flags_onehot;
                  state_q   <= StDone;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end
            end
            StDone: begin
               in_ready <= 1'b1;
               ser_rst  <= 1'b1;
               ser_op   <= 1'b1;
               state_q  <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_compare_driver.sv
// Directed bench for serial_compare_driver with a small bit-serial comparator model on the link.
module tb_serial_compare_driver;

   localparam int unsigned W   = 8;
   localparam int unsigned S   = 1;
   localparam int          Lat = 11;
   localparam int          Gap = 12;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         ser_a;
   logic         ser_b;
   logic         ser_rst;
   logic         ser_op;
   logic         cmp_l;
   logic         cmp_e;
   logic         cmp_g;
   logic         res_valid;
   logic         res_l;
   logic         res_e;
   logic         res_g;
   logic         res_err;

   int checks = 0;
   int errors = 0;

   logic       force_err = 1'b0;
   logic [1:0] cst;  // 0 equal so far, 1 A<B, 2 A>B

   always #5 clk = ~clk;

   serial_compare_driver #(.WIDTH(W), .SETTLE(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .ser_a     (ser_a),
      .ser_b     (ser_b),
      .ser_rst   (ser_rst),
      .ser_op    (ser_op),
      .cmp_l     (cmp_l),
      .cmp_e     (cmp_e),
      .cmp_g     (cmp_g),
      .res_valid (res_valid),
      .res_l     (res_l),
      .res_e     (res_e),
      .res_g     (res_g),
      .res_err   (res_err)
   );

   always @(posedge clk) begin
      if (ser_rst) cst <= 2'd0;
      else if (!ser_op && cst == 2'd0) begin
         if (ser_a && !ser_b) cst <= 2'd2;
         else if (!ser_a && ser_b) cst <= 2'd1;
      end
   end

   assign cmp_l = force_err | (!ser_op && cst == 2'd1);
   assign cmp_e = !force_err && !ser_op && cst == 2'd0;
   assign cmp_g = force_err | (!ser_op && cst == 2'd2);

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, ser_a, ser_b, ser_rst, ser_op, res_valid, res_l, res_e, res_g, res_err}
          !== 10'b0001100000) begin
         $display("FAIL reset_values: got %b required 0001100000",
                  {in_ready, ser_a, ser_b, ser_rst, ser_op, res_valid, res_l, res_e, res_g,
                   res_err});
         errors++;
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_ready_rise: in_ready=%b required 1", in_ready);
         errors++;
      end
   endtask

   // Runs one frame; pulse_at != 0 offers a bogus pair during that cycle of the frame.
   task automatic test_compare(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic el, input logic ee, input logic eg, input logic er,
                               input int pulse_at);
      int           lat;
      int           n;
      int           extra;
      logic [W-1:0] sa;
      logic [W-1:0] sb;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
         errors++;
         in_valid = 1'b0;
         return;
      end
      sa  = '0;
      sb  = '0;
      lat = 0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            in_valid = 1'b0;
            checks++;
            if ({ser_rst, ser_op, in_ready} !== 3'b100) begin
               $display("FAIL %s clear_cycle: rst/op/ready=%b required 100", name,
                        {ser_rst, ser_op, in_ready});
               errors++;
            end
         end
         if (lat >= 2 && lat < 2 + W) begin
            sa[W + 1 - lat] = ser_a;
            sb[W + 1 - lat] = ser_b;
         end
         if (pulse_at != 0 && lat == pulse_at) begin
            in_valid = 1'b1;
            in_a     = ~a;
            in_b     = a;
         end
         if (pulse_at != 0 && lat == pulse_at + 1) in_valid = 1'b0;
         if (res_valid === 1'b1) break;
      end
      checks++;
      if (lat !== Lat) begin
         $display("FAIL %s latency: got %0d required %0d", name, lat, Lat);
         errors++;
      end
      checks++;
      if (sa !== a || sb !== b) begin
         $display("FAIL %s serial_stream: a=%h b=%h required a=%h b=%h", name, sa, sb, a, b);
         errors++;
      end
      checks++;
      if ({res_l, res_e, res_g, res_err} !== {el, ee, eg, er}) begin
         $display("FAIL %s flags: l/e/g/err=%b required %b", name,
                  {res_l, res_e, res_g, res_err}, {el, ee, eg, er});
         errors++;
      end
      @(negedge clk);
      checks++;
      if ({in_ready, res_valid, res_l, res_e, res_g, res_err} !== {2'b10, el, ee, eg, er}) begin
         $display("FAIL %s idle_after_done: ready/valid/flags=%b required %b", name,
                  {in_ready, res_valid, res_l, res_e, res_g, res_err}, {2'b10, el, ee, eg, er});
         errors++;
      end
      if (pulse_at != 0) begin
         extra = 0;
         repeat (15) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || in_ready !== 1'b1) extra++;
         end
         checks++;
         if (extra != 0) begin
            $display("FAIL %s ignored_pulse: %0d bad idle cycles required 0", name, extra);
            errors++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int n;
      int first;
      int second;
      in_a     = 8'h3C;
      in_b     = 8'hC3;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      lat    = 0;
      first  = 0;
      second = 0;
      while (lat < 40 && second == 0) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            in_a = 8'hFF;
            in_b = 8'hFE;
         end
         if (res_valid === 1'b1 && first == 0) begin
            first = lat;
            checks++;
            if ({res_l, res_e, res_g, res_err} !== 4'b1000) begin
               $display("FAIL b2b_first_flags: l/e/g/err=%b required 1000",
                        {res_l, res_e, res_g, res_err});
               errors++;
            end
         end else if (res_valid === 1'b1) begin
            second = lat;
            checks++;
            if ({res_l, res_e, res_g, res_err} !== 4'b0010) begin
               $display("FAIL b2b_second_flags: l/e/g/err=%b required 0010",
                        {res_l, res_e, res_g, res_err});
               errors++;
            end
         end
         if (first != 0 && lat == first + 1) begin
            checks++;
            if (in_ready !== 1'b1) begin
               $display("FAIL b2b_idle_ready: in_ready=%b required 1", in_ready);
               errors++;
            end
         end
         if (first != 0 && lat == first + 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (first !== Lat || second - first !== Gap) begin
         $display("FAIL b2b_spacing: first=%0d gap=%0d required first=%0d gap=%0d", first,
                  second - first, Lat, Gap);
         errors++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int n;
      int extra;
      in_a     = 8'hFF;
      in_b     = 8'h00;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);  // clear
      in_valid = 1'b0;
      repeat (3) @(negedge clk);  // third shift cycle
      checks++;
      if ({ser_rst, ser_op, ser_a, ser_b} !== 4'b0010) begin
         $display("FAIL abort_mid_shift: rst/op/a/b=%b required 0010",
                  {ser_rst, ser_op, ser_a, ser_b});
         errors++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ser_rst, ser_op, in_ready, res_valid, ser_a} !== 5'b11000) begin
         $display("FAIL abort_reset_load: rst/op/ready/valid/a=%b required 11000",
                  {ser_rst, ser_op, in_ready, res_valid, ser_a});
         errors++;
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL abort_ready_rise: in_ready=%b required 1", in_ready);
         errors++;
      end
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (res_valid !== 1'b0) extra++;
      end
      checks++;
      if (extra != 0) begin
         $display("FAIL abort_no_result: %0d res_valid cycles required 0", extra);
         errors++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      test_reset();
      test_compare("eq_a5_a5", 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      test_compare("gt_80_7f", 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      test_compare("lt_00_01", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      test_back_to_back();
      test_reset_abort();
      test_compare("lt_7f_80", 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      force_err = 1'b1;
      test_compare("err_forced", 8'h12, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 4);
      force_err = 1'b0;
      test_compare("eq_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
